direct_sound_fifo: RTL and testbench
====================================

Name: direct_sound_fifo

Overview:
- Write-side FIFO feeding one Direct Sound channel (A or B); one instance per channel.
- Accepts CPU (16-bit) and DMA (32-bit) writes to the FIFO_A/FIFO_B register and packs lanes into 32-bit words.
- Stores up to DEPTH words and serves the channel's sample reader through FIFO_value/FIFO_re/FIFO_size/FIFO_clr.
- The reader uses FIFO_size to decide when to raise its DMA refill request.

Parameters:
DEPTH, 8, number of 32-bit words stored; power of two
DATA_W, 32, word width; byte-lane logic assumes 32

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  register write strobe to this channel's FIFO address
wr_be  input  4  byte-lane enables for wr_data
wr_data  input  32  write data
FIFO_re  input  1  reader pops head word
FIFO_clr  input  1  flush request from SOUNDCNT_H reset bit, via the reader
FIFO_value  output  32  head word, show-ahead
FIFO_size  output  4  stored word count, 0..DEPTH
full  output  1  FIFO_size == DEPTH
empty  output  1  FIFO_size == 0
overflow  output  1  one-cycle pulse: a completed word was dropped because the FIFO was full
underflow  output  1  one-cycle pulse: FIFO_re asserted while empty
drop_count  output  8  only with DIRECT_SOUND_FIFO_STATS_EN

Behaviour:
- Reset, synchronous and active-high. Pointers, count, staging word and lane-valid bits clear to 0.
  - Outputs after reset: FIFO_size=0, empty=1, full=0, FIFO_value=0, overflow=0, underflow=0, drop_count=0.
  - Stored memory contents are not cleared.
- Lane staging:
  - A 32-bit staging register plus 4 lane-valid bits.
  - When wr_en=1, each lane with wr_be[i]=1 is written into staging and marks that lane valid.
- Push condition: wr_en=1 and wr_be[3]=1.
  - Pushed word = staging merged with the current-cycle lanes. Current lanes win; lanes never written are 0.
  - Staging and lane-valid bits clear in the same cycle.
  - Resulting cases: wr_be=1111 pushes immediately. 0011 followed by 1100 pushes the assembled word. 1100 alone pushes {hi, 16'h0000}.
- Writes with wr_be[3]=0 only stage; nothing is pushed. wr_en=1 with wr_be=0000 is a no-op.
- Pop: FIFO_re=1 and count>0 advances the head pointer.
  - FIFO_re while empty: no state change, underflow pulses the next cycle.
- FIFO_value is combinational from mem[head] when count>0 and 0 when empty. It changes the cycle after a pop.
- Latency: a word pushed at edge N appears in FIFO_size and FIFO_value (if it is the head) after edge N.
- Simultaneous pop and push:
  - Not full: count unchanged, both take effect.
  - Full: the pop frees a slot and the push is accepted. No overflow; count stays DEPTH.
  - Empty: the pop is ignored (underflow pulses), the push is accepted, count becomes 1.
- Push while full with no pop: word dropped, staging still clears, overflow pulses the next cycle.
- FIFO_clr has highest priority below reset:
  - Clears pointers, count and staging.
  - Any same-cycle write or pop is discarded. No overflow or underflow pulse is generated.
- Pointer wrap-around uses log2(DEPTH)-bit pointers. Count is tracked separately with width log2(DEPTH)+1.
- Memory is plain registers, written only on an accepted push.

Optional Feature:
- Macro: DIRECT_SOUND_FIFO_STATS_EN.
- Defined: the drop_count port exists.
  - Saturating 8-bit counter, incremented on every overflow event and held at 255.
  - Cleared by reset and by FIFO_clr.
- Undefined: the drop_count port and counter are absent. All other behaviour is identical.

Decomposition:
- Package direct_sound_pkg holds:
  - DS_FIFO_DEPTH = 8 and DS_WORD_W = 32
  - typedef ds_word_t (logic [31:0])
  - typedef ds_count_t (logic [3:0])
  - lane-merge function merge_lanes(staging, data, be)
- No sub-module is needed. Staging, storage and counter fit in one module.

Test Plan:
- Reset then wr_be=1111 with 32'hAABB1122 -> next cycle FIFO_size=1, FIFO_value=32'hAABB1122, empty=0.
- wr_be=0011 with 32'h00001122, then wr_be=1100 with 32'hAABB0000 -> exactly one push of 32'hAABB1122; FIFO_size goes 0 to 1 only after the second write.
- 9 full-word writes of 0..8 with no pops -> FIFO_size=8, full=1, overflow pulses once on the 9th, pops return 0..7 in order; with the macro, drop_count=1.
- At full, assert push of 32'h9 and FIFO_re together -> FIFO_size stays 8, no overflow, last pop sequence ends with 32'h9.
- FIFO_re while empty -> underflow pulses one cycle, FIFO_size=0, FIFO_value=0.
- With 5 words stored, assert FIFO_clr together with a wr_be=1111 write -> next cycle FIFO_size=0, empty=1, write discarded, staging empty (a following 1100 write pushes {hi,16'h0}).

Source files
------------

// File: rtl/direct_sound_pkg.sv
// Shared definitions for the Direct Sound write-side FIFO.
//   DS_FIFO_DEPTH / DS_WORD_W : default storage depth and word width
//   ds_word_t / ds_count_t    : word and occupancy types
//   merge_lanes()             : byte-lane merge of staged data with a new write
package direct_sound_pkg;

  localparam int unsigned DS_FIFO_DEPTH = 8;
  localparam int unsigned DS_WORD_W     = 32;

  typedef logic [DS_WORD_W-1:0] ds_word_t;
  typedef logic [3:0]           ds_count_t;

  // Lanes enabled in be take data; the rest keep staging.
  function automatic ds_word_t merge_lanes(input ds_word_t   staging,
                                           input ds_word_t   data,
                                           input logic [3:0] be);
    ds_word_t merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? data[8*i +: 8] : staging[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/direct_sound_fifo.sv
// Write-side FIFO for one Direct Sound channel. CPU halfword and DMA word writes
// are packed into 32-bit words in a staging register; a write touching lane 3
// completes the word and pushes it. The sample reader pops words from the head.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   wr_en, wr_be, wr_data register write to this channel's FIFO address
//   FIFO_re, FIFO_clr     reader pop and flush
//   FIFO_value            show-ahead head word (0 when empty)
//   FIFO_size             stored word count, 0..DEPTH
//   full, empty           occupancy flags
//   overflow, underflow   one-cycle pulses after a dropped push / empty pop
//   drop_count            saturating overflow count (DIRECT_SOUND_FIFO_STATS_EN only)
//
// Build option: define DIRECT_SOUND_FIFO_STATS_EN to add the drop_count port.
module direct_sound_fifo
  import direct_sound_pkg::*;
#(
  parameter int unsigned DEPTH  = DS_FIFO_DEPTH,
  parameter int unsigned DATA_W = DS_WORD_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [3:0]                wr_be,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      FIFO_re,
  input  logic                      FIFO_clr,
  output logic [DATA_W-1:0]         FIFO_value,
  output logic [$clog2(DEPTH):0]    FIFO_size,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow
`ifdef DIRECT_SOUND_FIFO_STATS_EN
  ,
  output logic [7:0]                drop_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  ds_word_t          staging_q, staging_d;
  logic [3:0]        lane_valid_q, lane_valid_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;

  logic              push_req, do_push, do_pop, mem_we;
  ds_word_t          staged_lanes, push_word;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  always_comb begin
    staged_lanes = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_valid_q[i]) staged_lanes[8*i +: 8] = staging_q[8*i +: 8];
    end
  end

  assign push_word = merge_lanes(staged_lanes, wr_data, wr_be);

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    staging_d    = staging_q;
    lane_valid_d = lane_valid_q;
    mem_we       = 1'b0;

    push_req = wr_en & wr_be[3];
    do_pop   = FIFO_re & ~empty;
    // A same-cycle pop frees the slot a full FIFO needs for the push.
    do_push  = push_req & (~full | do_pop);

    overflow_d  = push_req & ~do_push;
    underflow_d = FIFO_re & empty;

    if (wr_en) begin
      if (wr_be[3]) begin
        // Word completes (stored or dropped): staging always restarts.
        staging_d    = '0;
        lane_valid_d = '0;
      end else begin
        staging_d    = merge_lanes(staging_q, wr_data, wr_be);
        lane_valid_d = lane_valid_q | wr_be;
      end
    end

    if (do_pop)  head_d = head_q + 1'b1;
    if (do_push) tail_d = tail_q + 1'b1;
    mem_we = do_push;

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (FIFO_clr) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      staging_d    = '0;
      lane_valid_d = '0;
      mem_we       = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      staging_q    <= '0;
      lane_valid_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      staging_q    <= staging_d;
      lane_valid_q <= lane_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is not reset; empty masks stale contents from FIFO_value.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem_q[tail_q] <= push_word;
  end

  assign FIFO_value = empty ? '0 : mem_q[head_q];
  assign FIFO_size  = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

`ifdef DIRECT_SOUND_FIFO_STATS_EN
  logic [7:0] drop_q;

  always_ff @(posedge clock) begin
    if (reset || FIFO_clr) begin
      drop_q <= '0;
    end else if (overflow_d && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Self-checking bench for direct_sound_fifo: directed scenarios plus a randomized
// run, all checked against a queue-based reference model of the FIFO.
module tb_direct_sound_fifo;
  import direct_sound_pkg::*;

  localparam int unsigned Depth = DS_FIFO_DEPTH;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        FIFO_re;
  logic        FIFO_clr;
  logic [31:0] FIFO_value;
  ds_count_t   FIFO_size;
  logic        full, empty, overflow, underflow;
`ifdef DIRECT_SOUND_FIFO_STATS_EN
  logic [7:0]  drop_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: stored words, staged bytes (unwritten = 0), expected pulses.
  logic [31:0] m_q[$];
  logic [7:0]  m_stg[4];
  int unsigned m_drops;
  logic        m_ovf, m_unf;

  direct_sound_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .FIFO_re    (FIFO_re),
    .FIFO_clr   (FIFO_clr),
    .FIFO_value (FIFO_value),
    .FIFO_size  (FIFO_size),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef DIRECT_SOUND_FIFO_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic idle();
    wr_en    = 1'b0;
    wr_be    = 4'b0000;
    wr_data  = 32'h0;
    FIFO_re  = 1'b0;
    FIFO_clr = 1'b0;
  endtask

  // Advance the model by the current inputs, then let the DUT clock once.
  task automatic tick();
    logic [31:0] word;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (reset || FIFO_clr) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_stg[i] = 8'h00;
      m_drops = 0;
    end else begin
      if (FIFO_re) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_unf = 1'b1;
      end
      if (wr_en) begin
        for (int i = 0; i < 4; i++) if (wr_be[i]) m_stg[i] = wr_data[8*i +: 8];
        if (wr_be[3]) begin
          word = {m_stg[3], m_stg[2], m_stg[1], m_stg[0]};
          if (m_q.size() < Depth) m_q.push_back(word);
          else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
          end
          for (int i = 0; i < 4; i++) m_stg[i] = 8'h00;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [3:0] be, input logic [31:0] data);
    idle();
    wr_en   = 1'b1;
    wr_be   = be;
    wr_data = data;
    tick();
    idle();
  endtask

  task automatic pop();
    idle();
    FIFO_re = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (FIFO_size !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || FIFO_value !== 32'h0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: size=%0d empty=%b full=%b value=%h ovf=%b unf=%b, required 0/1/0/0/0/0",
               FIFO_size, empty, full, FIFO_value, overflow, underflow);
    end
`ifdef DIRECT_SOUND_FIFO_STATS_EN
    n_cmp++;
    if (drop_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_drop_count: got %0d required 0", drop_count);
    end
`endif
  endtask

  task automatic test_full_word();
    write(4'b1111, 32'hAABB1122);
    n_cmp++;
    if (FIFO_size !== 4'd1 || FIFO_value !== 32'hAABB1122 || empty !== 1'b0) begin
      n_bad++;
      $display("FAIL full_word: size=%0d value=%h empty=%b, required 1/aabb1122/0",
               FIFO_size, FIFO_value, empty);
    end
    pop();
    n_cmp++;
    if (FIFO_size !== 4'd0 || FIFO_value !== 32'h0) begin
      n_bad++;
      $display("FAIL full_word_pop: size=%0d value=%h, required 0/0", FIFO_size, FIFO_value);
    end
  endtask

  task automatic test_half_words();
    write(4'b0011, 32'h00001122);
    n_cmp++;
    if (FIFO_size !== 4'd0) begin
      n_bad++;
      $display("FAIL half_low_no_push: size=%0d required 0", FIFO_size);
    end
    write(4'b1100, 32'hAABB0000);
    n_cmp++;
    if (FIFO_size !== 4'd1 || FIFO_value !== 32'hAABB1122) begin
      n_bad++;
      $display("FAIL half_assemble: size=%0d value=%h, required 1/aabb1122",
               FIFO_size, FIFO_value);
    end
    write(4'b0000, 32'hFFFFFFFF);
    write(4'b1100, 32'h5566FFFF);
    n_cmp++;
    if (FIFO_size !== 4'd2) begin
      n_bad++;
      $display("FAIL hi_only_push: size=%0d required 2", FIFO_size);
    end
    pop();
    n_cmp++;
    if (FIFO_value !== 32'h55660000) begin
      n_bad++;
      $display("FAIL hi_only_word: value=%h required 55660000", FIFO_value);
    end
    pop();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 9; i++) begin
      write(4'b1111, 32'(i));
      n_cmp++;
      if (overflow !== (i == 8)) begin
        n_bad++;
        $display("FAIL fill_overflow[%0d]: overflow=%b required %b", i, overflow, (i == 8));
      end
    end
    n_cmp++;
    if (FIFO_size !== 4'd8 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_full: size=%0d full=%b, required 8/1", FIFO_size, full);
    end
`ifdef DIRECT_SOUND_FIFO_STATS_EN
    n_cmp++;
    if (drop_count !== 8'd1) begin
      n_bad++;
      $display("FAIL drop_count: got %0d required 1", drop_count);
    end
`endif
    idle();
    tick();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_one_cycle: overflow=%b required 0", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (FIFO_value !== 32'(i)) begin
        n_bad++;
        $display("FAIL drain[%0d]: value=%h required %h", i, FIFO_value, 32'(i));
      end
      pop();
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_empty: empty=%b required 1", empty);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) write(4'b1111, 32'(i));
    idle();
    wr_en   = 1'b1;
    wr_be   = 4'b1111;
    wr_data = 32'h9;
    FIFO_re = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (FIFO_size !== 4'd8 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_push_pop: size=%0d ovf=%b, required 8/0", FIFO_size, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (FIFO_value !== ((i == 7) ? 32'h9 : 32'(i + 1))) begin
        n_bad++;
        $display("FAIL full_push_pop_drain[%0d]: value=%h required %h", i, FIFO_value,
                 (i == 7) ? 32'h9 : 32'(i + 1));
      end
      pop();
    end
  endtask

  task automatic test_underflow();
    pop();
    n_cmp++;
    if (underflow !== 1'b1 || FIFO_size !== 4'd0 || FIFO_value !== 32'h0) begin
      n_bad++;
      $display("FAIL underflow: unf=%b size=%0d value=%h, required 1/0/0",
               underflow, FIFO_size, FIFO_value);
    end
    tick();
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL underflow_one_cycle: unf=%b required 0", underflow);
    end
    // Pop and push together while empty: push wins, underflow still pulses.
    idle();
    wr_en   = 1'b1;
    wr_be   = 4'b1111;
    wr_data = 32'hCAFE0001;
    FIFO_re = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (underflow !== 1'b1 || FIFO_size !== 4'd1 || FIFO_value !== 32'hCAFE0001) begin
      n_bad++;
      $display("FAIL empty_push_pop: unf=%b size=%0d value=%h, required 1/1/cafe0001",
               underflow, FIFO_size, FIFO_value);
    end
    pop();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) write(4'b1111, 32'h100 + 32'(i));
    write(4'b0011, 32'h0000BEEF);
    idle();
    FIFO_clr = 1'b1;
    wr_en    = 1'b1;
    wr_be    = 4'b1111;
    wr_data  = 32'h12345678;
    tick();
    idle();
    n_cmp++;
    if (FIFO_size !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: size=%0d empty=%b ovf=%b unf=%b, required 0/1/0/0",
               FIFO_size, empty, overflow, underflow);
    end
    write(4'b1100, 32'hDEAD5678);
    n_cmp++;
    if (FIFO_size !== 4'd1 || FIFO_value !== 32'hDEAD0000) begin
      n_bad++;
      $display("FAIL clear_staging: size=%0d value=%h, required 1/dead0000",
               FIFO_size, FIFO_value);
    end
    pop();
  endtask

  task automatic test_random();
    logic [31:0] exp_val;
    for (int c = 0; c < 600; c++) begin
      idle();
      wr_en   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       wr_be = 4'b1111;
        1:       wr_be = 4'b0011;
        2:       wr_be = 4'b1100;
        3:       wr_be = 4'b0000;
        default: wr_be = 4'($urandom_range(0, 15));
      endcase
      wr_data  = $urandom;
      // Push-heavy, then pop-heavy phases to reach both full and empty.
      FIFO_re  = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      FIFO_clr = ($urandom_range(0, 79) == 0);
      tick();
      exp_val = (m_q.size() > 0) ? m_q[0] : 32'h0;
      n_cmp++;
      if (FIFO_size !== 4'(m_q.size()) || FIFO_value !== exp_val ||
          full !== (m_q.size() == Depth) || empty !== (m_q.size() == 0)) begin
        n_bad++;
        $display("FAIL random[%0d]: size=%0d value=%h full=%b empty=%b, required %0d/%h/%b/%b",
                 c, FIFO_size, FIFO_value, full, empty, m_q.size(), exp_val,
                 (m_q.size() == Depth), (m_q.size() == 0));
      end
      n_cmp++;
      if (overflow !== m_ovf || underflow !== m_unf) begin
        n_bad++;
        $display("FAIL random_pulse[%0d]: ovf=%b unf=%b, required %b/%b",
                 c, overflow, underflow, m_ovf, m_unf);
      end
`ifdef DIRECT_SOUND_FIFO_STATS_EN
      n_cmp++;
      if (drop_count !== 8'(m_drops)) begin
        n_bad++;
        $display("FAIL random_drops[%0d]: got %0d required %0d", c, drop_count, m_drops);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_full_word();
    test_half_words();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
